regfile_mp: RTL and testbench

- Parametrised multi-port register file. Successor to the single-write, two-read 32x32 register file.
- Adds configurable width, depth and read-port count, plus two write ports with fixed priority.
- Adds optional write-to-read bypass, asynchronous reset of all storage, and a per-register busy scoreboard for multi-cycle producers.
- Sits between decode (read addresses), writeback (two retire lanes) and the issue stage (busy check).

---
 rtl/regfile_mp.sv | 132 +++++++++++++
 tb/tb_regfile_mp.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
// Two write lanes (lane 1 has priority), NUM_RD combinational read ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       busy_set,
    input  logic [ADDR_W-1:0]          busy_addr,
    output logic [NUM_REGS-1:0]        busy_vec,
    output logic                       wr_conflict
);

    // Register count in a width that can hold NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0] NREGS_A = (ADDR_W + 1)'(NUM_REGS);

    // An address names a real, writable register: in range and not the
    // hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_A) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic                conflict_q;

    logic w0_ok;
    logic w1_ok;
    logic set_ok;

    assign w0_ok  = we0 && addr_ok(wa0);
    assign w1_ok  = we1 && addr_ok(wa1);
    assign set_ok = busy_set && addr_ok(busy_addr);

    // Register storage: lane 1 overrides lane 0 when both target one register.
    // NOTE: the whole array is reset, so it maps to flops rather than a RAM
    //       macro; that is what guarantees every register reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                // NOTE: sequential state uses non-blocking assignments so every
                //       flop samples pre-edge values regardless of block order.
                if (w1_ok && (wa1 == ADDR_W'(r))) begin
                    mem[r] <= wd1;
                end else if (w0_ok && (wa0 == ADDR_W'(r))) begin
                    mem[r] <= wd0;
                end
            end
        end
    end

    // Scoreboard: a new busy_set beats a retiring write to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (set_ok && (busy_addr == ADDR_W'(r))) begin
                    busy_q[r] <= 1'b1;
                end else if ((w0_ok && (wa0 == ADDR_W'(r))) ||
                             (w1_ok && (wa1 == ADDR_W'(r)))) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    // One-cycle flag when both lanes commit to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= w0_ok && w1_ok && (wa0 == wa1);
        end
    end

    assign busy_vec    = busy_q;
    assign wr_conflict = conflict_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;
        logic              hit0;
        logic              hit1;

        assign a    = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit1 = (BYPASS != 0) && w1_ok && (wa1 == a);
        assign hit0 = (BYPASS != 0) && w0_ok && (wa0 == a);

        // Read mux: forwarded write data first, otherwise stored value and busy.
        always_comb begin
            // NOTE: defaults before the branches keep this purely
            //       combinational; a missing else would infer a latch.
            d = '0;
            b = 1'b0;
            if (addr_ok(a)) begin
                if (hit1) begin
                    d = wd1;
                end else if (hit0) begin
                    d = wd0;
                end else begin
                    d = mem[a];
                    b = busy_q[a];
                end
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = d;
        assign rd_busy[i]                  = b;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against a
// behavioural model of the register file, plus BYPASS=0 and wide variants.
module tb_regfile_mp;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    // ---------------- default instance (BYPASS=1, ZERO_REG=1) --------------
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1, busy_set;
    logic [4:0]  wa0, wa1, busy_addr;
    logic [31:0] wd0, wd1;
    logic [31:0] busy_vec;
    logic        wr_conflict;

    regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .busy_vec(busy_vec), .wr_conflict(wr_conflict)
    );

    // ---------------- BYPASS=0 instance ------------------------------------
    logic [9:0]  nb_rd_addr;
    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_busy;
    logic        nb_we0, nb_we1, nb_busy_set;
    logic [4:0]  nb_wa0, nb_wa1, nb_busy_addr;
    logic [31:0] nb_wd0, nb_wd1;
    logic [31:0] nb_busy_vec;
    logic        nb_wr_conflict;

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(nb_rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .we0(nb_we0), .wa0(nb_wa0), .wd0(nb_wd0),
        .we1(nb_we1), .wa1(nb_wa1), .wd1(nb_wd1),
        .busy_set(nb_busy_set), .busy_addr(nb_busy_addr),
        .busy_vec(nb_busy_vec), .wr_conflict(nb_wr_conflict)
    );

    // ---------------- wide instance: 24 regs, 4 read ports, 64-bit ---------
    logic [19:0]  w_rd_addr;
    logic [255:0] w_rd_data;
    logic [3:0]   w_rd_busy;
    logic         w_we0, w_we1, w_busy_set;
    logic [4:0]   w_wa0, w_wa1, w_busy_addr;
    logic [63:0]  w_wd0, w_wd1;
    logic [23:0]  w_busy_vec;
    logic         w_wr_conflict;

    regfile_mp #(.DATA_W(64), .NUM_REGS(24), .NUM_RD(4)) u_wide (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
        .we0(w_we0), .wa0(w_wa0), .wd0(w_wd0),
        .we1(w_we1), .wa1(w_wa1), .wd1(w_wd1),
        .busy_set(w_busy_set), .busy_addr(w_busy_addr),
        .busy_vec(w_busy_vec), .wr_conflict(w_wr_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model of the default instance --------------
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    logic        m_conf;

    // Writable register: r0 is hardwired, all 32 addresses are implemented.
    function automatic bit m_valid(input logic [4:0] a);
        return a != 5'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (!m_valid(a)) return 32'd0;
        if (we1 && m_valid(wa1) && wa1 == a) return wd1;
        if (we0 && m_valid(wa0) && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a);
        if (!m_valid(a)) return 1'b0;
        if ((we1 && m_valid(wa1) && wa1 == a) || (we0 && m_valid(wa0) && wa0 == a))
            return 1'b0;
        return m_busy[a];
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) m_mem[r] = 32'd0;
        m_busy = 32'd0;
        m_conf = 1'b0;
    endtask

    // Apply one clock edge to the model: lane 0, then lane 1 (lane 1 wins),
    // then a busy_set (set wins over the clear from a write).
    task automatic m_update();
        logic nconf;
        nconf = we0 && we1 && m_valid(wa0) && m_valid(wa1) && (wa0 == wa1);
        if (we0 && m_valid(wa0)) begin m_mem[wa0] = wd0; m_busy[wa0] = 1'b0; end
        if (we1 && m_valid(wa1)) begin m_mem[wa1] = wd1; m_busy[wa1] = 1'b0; end
        if (busy_set && m_valid(busy_addr)) m_busy[busy_addr] = 1'b1;
        m_conf = nconf;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < 2; p++) begin
            logic [4:0] a;
            a = rd_addr[p*5 +: 5];
            chk($sformatf("%s rd_data%0d", tag, p), 64'(rd_data[p*32 +: 32]), 64'(m_read(a)));
            chk($sformatf("%s rd_busy%0d", tag, p), 64'(rd_busy[p]), 64'(m_rbusy(a)));
        end
        chk({tag, " busy_vec"}, 64'(busy_vec), 64'(m_busy));
        chk({tag, " wr_conflict"}, 64'(wr_conflict), 64'(m_conf));
    endtask

    // One clock: model follows the edge, then return at the falling edge
    // where the next inputs are applied.
    task automatic cycle();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic idle_main();
        we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0;
        busy_set = 0; busy_addr = 0;
    endtask

    task automatic idle_others();
        nb_we0 = 0; nb_wa0 = 0; nb_wd0 = 0; nb_we1 = 0; nb_wa1 = 0; nb_wd1 = 0;
        nb_busy_set = 0; nb_busy_addr = 0; nb_rd_addr = 0;
        w_we0 = 0; w_wa0 = 0; w_wd0 = 0; w_we1 = 0; w_wa1 = 0; w_wd1 = 0;
        w_busy_set = 0; w_busy_addr = 0; w_rd_addr = 0;
    endtask

    // Address biased to low registers so collisions and hazards are common.
    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    logic [63:0] wv [4];

    initial begin
        rst_n = 1'b0;
        rd_addr = '0;
        idle_main();
        idle_others();
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        rd_addr = {5'd6, 5'd5};
        #1;
        chk("reset busy_vec", 64'(busy_vec), 64'd0);
        chk("reset wr_conflict", 64'(wr_conflict), 64'd0);
        check_all("reset");

        // Write r5, mark r6 busy, then asynchronous reset mid-cycle
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
        busy_set = 1; busy_addr = 6;
        #1 check_all("pre_rst_write");
        cycle();
        idle_main();
        #1;
        chk("r5 written", 64'(rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);
        chk("r6 busy", 64'(busy_vec[6]), 64'd1);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("async rst r5", 64'(rd_data[31:0]), 64'd0);
        chk("async rst busy_vec", 64'(busy_vec), 64'd0);
        chk("async rst wr_conflict", 64'(wr_conflict), 64'd0);
        check_all("async_rst");
        #1 rst_n = 1'b1;
        cycle();

        // Dual write to distinct registers
        we0 = 1; wa0 = 3; wd0 = 32'h11;
        we1 = 1; wa1 = 7; wd1 = 32'h22;
        cycle();
        idle_main();
        rd_addr = {5'd7, 5'd3};
        #1;
        chk("dual r3", 64'(rd_data[31:0]), 64'h11);
        chk("dual r7", 64'(rd_data[63:32]), 64'h22);
        chk("dual no conflict", 64'(wr_conflict), 64'd0);
        check_all("dual");

        // Collision on r9: lane 1 wins, one-cycle conflict pulse
        we0 = 1; wa0 = 9; wd0 = 32'hAAAA;
        we1 = 1; wa1 = 9; wd1 = 32'hBBBB;
        cycle();
        idle_main();
        rd_addr = {5'd0, 5'd9};
        #1;
        chk("collide r9", 64'(rd_data[31:0]), 64'hBBBB);
        chk("collide flag", 64'(wr_conflict), 64'd1);
        check_all("collide");
        cycle();
        #1 chk("collide flag drop", 64'(wr_conflict), 64'd0);

        // Collision on r0 is dropped and does not flag
        we0 = 1; wa0 = 0; wd0 = 32'h1;
        we1 = 1; wa1 = 0; wd1 = 32'h2;
        cycle();
        idle_main();
        #1;
        chk("r0 collide data", 64'(rd_data[63:32]), 64'd0);
        chk("r0 collide flag", 64'(wr_conflict), 64'd0);

        // Same-cycle bypass
        rd_addr = {5'd0, 5'd4};
        we0 = 1; wa0 = 4; wd0 = 32'h1234;
        #1 chk("bypass r4", 64'(rd_data[31:0]), 64'h1234);
        check_all("bypass");
        cycle();
        idle_main();

        // Scoreboard sequencing on r12
        busy_set = 1; busy_addr = 12;
        cycle();
        idle_main();
        rd_addr = {5'd0, 5'd12};
        #1;
        chk("sb set vec", 64'(busy_vec[12]), 64'd1);
        chk("sb set rd_busy", 64'(rd_busy[0]), 64'd1);
        we1 = 1; wa1 = 12; wd1 = 32'h77;
        #1;
        chk("sb write bypass", 64'(rd_busy[0]), 64'd0);
        check_all("sb_write");
        cycle();
        idle_main();
        #1 chk("sb cleared", 64'(busy_vec[12]), 64'd0);
        busy_set = 1; busy_addr = 12;
        we0 = 1; wa0 = 12; wd0 = 32'h88;
        cycle();
        idle_main();
        #1 chk("sb set wins", 64'(busy_vec[12]), 64'd1);
        check_all("sb_setwins");

        // BYPASS=0: old value this cycle, new value next cycle
        nb_we0 = 1; nb_wa0 = 4; nb_wd0 = 32'h5555;
        cycle();
        nb_rd_addr = {5'd0, 5'd4};
        nb_wd0 = 32'h1234;
        #1 chk("nobyp old", 64'(nb_rd_data[31:0]), 64'h5555);
        cycle();
        nb_we0 = 0;
        #1 chk("nobyp new", 64'(nb_rd_data[31:0]), 64'h1234);

        // Wide instance: out-of-range write/busy dropped, four independent ports
        w_we0 = 1; w_wa0 = 30; w_wd0 = 64'hCAFE_F00D_1234_5678;
        w_busy_set = 1; w_busy_addr = 30;
        w_rd_addr = {5'd0, 5'd0, 5'd0, 5'd30};
        #1 chk("wide r30 same cycle", w_rd_data[63:0], 64'd0);
        cycle();
        w_we0 = 0; w_busy_set = 0;
        #1;
        chk("wide r30 after", w_rd_data[63:0], 64'd0);
        chk("wide busy_vec", 64'(w_busy_vec), 64'd0);
        for (int k = 0; k < 4; k++) wv[k] = {$urandom, $urandom};
        w_we0 = 1; w_wa0 = 1; w_wd0 = wv[0];
        w_we1 = 1; w_wa1 = 2; w_wd1 = wv[1];
        cycle();
        w_wa0 = 3; w_wd0 = wv[2];
        w_wa1 = 23; w_wd1 = wv[3];
        cycle();
        w_we0 = 0; w_we1 = 0;
        w_rd_addr = {5'd23, 5'd3, 5'd2, 5'd1};
        #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("wide port%0d", k), w_rd_data[k*64 +: 64], wv[k]);
        chk("wide no conflict", 64'(w_wr_conflict), 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            we0 = 1'($urandom_range(0, 1)); wa0 = rnd_addr(); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = rnd_addr(); wd1 = $urandom;
            busy_set = ($urandom_range(0, 9) < 3); busy_addr = rnd_addr();
            rd_addr = {rnd_addr(), rnd_addr()};
            #1 check_all("rand");
            cycle();
        end
        idle_main();
        #1 check_all("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
